stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
//
// PURPOSE
// - Parametrised N:1 stream multiplexer with a one-entry registered output stage and valid/ready handshake.
// - Successor to the combinational 2:1 mux: generalised in width and channel count, adds flow control, a channel tag and optional round-robin selection.
// - Sits between several producer streams and one consumer; 1-cycle latency, full throughput (1 beat/cycle).
//
// PARAMETERS
// - WIDTH  default 8  data bits per channel
// - NCH    default 4  number of input channels, >= 2
// - SELW   localparam = $clog2(NCH); width of sel / out_ch
//
// PORTS
// - clk        in   1           single clock, all logic on rising edge
// - rst        in   1           synchronous reset, active-high
// - in_data    in   NCH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
// - in_valid   in   NCH         per-channel valid
// - in_ready   out  NCH         per-channel ready (combinational)
// - sel        in   SELW        channel select (fixed-select mode only)
// - out_data   out  WIDTH       registered data
// - out_ch     out  SELW        registered index of the source channel
// - out_valid  out  1           registered valid
// - out_ready  in   1           consumer ready
//
// BEHAVIOUR
// - Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, RR pointer=0; in_ready all 0 while rst=1.
// - load = ~out_valid | out_ready (output slot free or draining this cycle).
// - grant g selected per mode (below); in_ready[i] = load & (i==g) & grant_ok; other bits 0.
// - Transfer on channel i when in_valid[i] & in_ready[i]; at that edge out_data<=chan g data, out_ch<=g, out_valid<=1.
// - load=1 with no transfer: out_valid<=0 (out_data/out_ch hold last value).
// - load=0 (out_valid=1, out_ready=0): out_* hold stable; all in_ready=0; no data dropped or duplicated.
// - Simultaneous drain+fill: out_ready=1 with new transfer -> back-to-back beats, no bubble.
// - Latency: input accepted at edge k appears on out_* from edge k (visible cycle k+1).
// - Fixed-select mode: g=sel; grant_ok = (sel < NCH); sel >= NCH -> no channel ready, no transfer.
//   sel may change any cycle; beats already registered are unaffected.
// - rst asserted mid-stream: registered beat is discarded, out_valid=0 next cycle.
//
// CONFIGURATION
// - MUX_ROUND_ROBIN_EN defined: sel ignored; g = first channel with in_valid set, searching
//   ptr, ptr+1 ... NCH-1, 0 ... ptr-1 (wrap); grant_ok = |in_valid.
//   On each transfer ptr <= (g==NCH-1) ? 0 : g+1; ptr holds otherwise (incl. stall).
//   Grant is stable while load=0, so a stalled request is not re-arbitrated away.
// - Not defined: fixed-select mode as above; no pointer register synthesised.
//
// TESTING
// - Reset: rst=1 two cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
// - Fixed sel=2, in_valid=4'b0100, ch2 data 0xA5, out_ready=1 -> next cycle out_data=0xA5, out_ch=2, out_valid=1.
// - Backpressure: out_valid=1, out_ready=0 for 3 cycles, ch1 valid -> in_ready=0, out_data stable; out_ready=1 -> ch1 beat follows next cycle.
// - Streaming: sel=0, ch0 valid with 0x01..0x08 consecutive, out_ready=1 -> 8 beats back-to-back, in order, no bubbles.
// - Out-of-range: NCH=3, sel=3, all valid -> in_ready=3'b000, out_valid falls to 0.
// - RR (MUX_ROUND_ROBIN_EN): all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,...; only ch2 valid -> out_ch=2 every cycle.

Source files
------------

// File: rtl/stream_mux_n.sv
// N:1 valid/ready stream mux with a one-entry registered output slot and source tag.
// Define MUX_ROUND_ROBIN_EN to replace the sel input with a rotating-priority arbiter.
module stream_mux_n #(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic              load;
   logic              grant_ok;
   logic              xfer;
   logic [SELW-1:0]   g;
   logic [WIDTH-1:0]  g_data;

   assign load = ~out_valid | out_ready;

`ifdef MUX_ROUND_ROBIN_EN
   logic [SELW-1:0] ptr;
   logic            found;
   int              idx;
   logic            unused_sel;

   assign unused_sel = ^sel;
   assign grant_ok   = |in_valid;

   // First requester at or after ptr, wrapping; ptr only moves on a transfer,
   // so a stalled grant stays put until the slot frees.
   always_comb begin
      g     = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            g     = SELW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (xfer)
         ptr <= (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;
   end
`else
   localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

   assign g        = sel;
   assign grant_ok = ({1'b0, sel} < NCH_W);
`endif

   always_comb begin
      in_ready = '0;
      g_data   = '0;
      for (int i = 0; i < NCH; i++) begin
         in_ready[i] = ~rst & load & grant_ok & (g == SELW'(i));
         if (g == SELW'(i)) g_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= g_data;
            out_ch   <= g;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: vector table, corner sequences and a
// randomized run against a slot-level reference model (fixed or round-robin build).
module tb_stream_mux_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        rst3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_mux_n #(.WIDTH(8), .NCH(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_mux_n #(.WIDTH(8), .NCH(3)) dut3 (
      .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .sel(sel3), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are set #1 after a rising edge; combinational ready is checked
   // #1 later, registered outputs #1 after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic [3:0]  iv;
      logic        ordy;
      logic [3:0]  e_ir;
      logic        e_v;
      logic [7:0]  e_d;
      logic [1:0]  e_c;
   } vec_t;

   vec_t vt[10];

   // Reference state: contents of the single output slot.
   logic       m_v;
   logic [7:0] m_d;
   logic [1:0] m_c;
   int         m_ptr;

   initial begin
      rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b1;
      rst3 = 1'b1; in_data3 = '0; in_valid3 = '0; sel3 = '0; out_ready3 = 1'b1;
      #1;

`ifndef MUX_ROUND_ROBIN_EN
      // ch3=44 ch2=A5 ch1=22 ch0=11
      vt[0] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      vt[1] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      vt[2] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vt[3] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
      vt[4] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
      vt[5] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
      vt[6] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vt[7] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h22, 2'd1};
      vt[8] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
      vt[9] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      in_data = 32'h44A5_2211;
      for (int i = 0; i < 10; i++) begin
         rst = vt[i].rst; sel = vt[i].sel; in_valid = vt[i].iv; out_ready = vt[i].ordy;
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
         tick();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_v));
         chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vt[i].e_d));
         chk($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vt[i].e_c));
      end

      // Streaming: 8 consecutive beats on ch0, no bubbles, in order.
      sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = {24'h0, 8'(i + 1)};
         tick();
         chk($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d data", i), 32'(out_data), 32'(i + 1));
      end

      // Mid-stream reset discards the held beat.
      out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111;
      #1;
      chk("midrst in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_data", 32'(out_data), 32'd0);
      rst = 1'b0;

      // Out-of-range select on a 3-channel instance.
      rst3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; in_data3 = 24'h33_22_11;
      tick();
      chk("oor prefill valid", 32'(out_valid3), 32'd1);
      sel3 = 2'd3;
      #1;
      chk("oor in_ready", 32'(in_ready3), 32'd0);
      tick();
      chk("oor out_valid", 32'(out_valid3), 32'd0);

      // Randomized run against the slot model.
      rst = 1'b1; tick(); rst = 1'b0;
      m_v = 1'b0; m_d = '0; m_c = '0;
      for (int n = 0; n < 400; n++) begin
         logic       ld;
         logic [3:0] e_ir;
         rst       = ($urandom_range(0, 19) == 0);
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         ld   = !m_v || out_ready;
         e_ir = (!rst && ld) ? (4'b0001 << sel) : 4'b0000;
         #1;
         chk("rand in_ready", 32'(in_ready), 32'(e_ir));
         if (rst) begin
            m_v = 1'b0; m_d = '0; m_c = '0;
         end else if (ld) begin
            m_v = in_valid[sel];
            if (in_valid[sel]) begin
               m_d = in_data[sel*8 +: 8];
               m_c = sel;
            end
         end
         tick();
         chk("rand out_valid", 32'(out_valid), 32'(m_v));
         if (m_v) begin
            chk("rand out_data", 32'(out_data), 32'(m_d));
            chk("rand out_ch", 32'(out_ch), 32'(m_c));
         end
      end
`else
      tick(); tick();
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0; in_data = 32'h44A5_2211; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("rr all ch%0d", i), 32'(out_ch), 32'(i % 4));
         chk($sformatf("rr all data%0d", i), 32'(out_data), 32'(in_data[(i % 4)*8 +: 8]));
      end
      in_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rr ch2 only %0d", i), 32'(out_ch), 32'd2);
         chk($sformatf("rr ch2 valid %0d", i), 32'(out_valid), 32'd1);
      end

      // Randomized run: rotating priority over an integer pointer.
      rst = 1'b1; tick(); rst = 1'b0;
      m_v = 1'b0; m_d = '0; m_c = '0; m_ptr = 0;
      for (int n = 0; n < 400; n++) begin
         logic       ld;
         int         gg;
         logic [3:0] e_ir;
         rst       = ($urandom_range(0, 19) == 0);
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         ld = !m_v || out_ready;
         gg = -1;
         for (int k = 3; k >= 0; k--)
            if (in_valid[(m_ptr + k) % 4]) gg = (m_ptr + k) % 4;
         e_ir = (!rst && ld && gg >= 0) ? (4'b0001 << gg) : 4'b0000;
         #1;
         chk("rrand in_ready", 32'(in_ready), 32'(e_ir));
         if (rst) begin
            m_v = 1'b0; m_d = '0; m_c = '0; m_ptr = 0;
         end else if (ld) begin
            m_v = (gg >= 0);
            if (gg >= 0) begin
               m_d = in_data[gg*8 +: 8];
               m_c = 2'(gg);
               m_ptr = (gg + 1) % 4;
            end
         end
         tick();
         chk("rrand out_valid", 32'(out_valid), 32'(m_v));
         if (m_v) begin
            chk("rrand out_data", 32'(out_data), 32'(m_d));
            chk("rrand out_ch", 32'(out_ch), 32'(m_c));
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
